// File: rtl/hamming74_decoder.sv
// Hamming(7,4) single-error-correcting decoder with a registered data output.
// Define HAMMING74_ERR_STATUS_EN to also register the syndrome and an error flag.
module hamming74_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] codeword,
  output logic [3:0] data
`ifdef HAMMING74_ERR_STATUS_EN
  ,
  output logic [2:0] syndrome,
  output logic       err_corrected
`endif
);

  logic [2:0] syn;
  logic [6:0] corrected;
  logic [3:0] data_next;

  always_comb begin
    syn[0] = codeword[0] ^ codeword[2] ^ codeword[4] ^ codeword[6];
    syn[1] = codeword[1] ^ codeword[2] ^ codeword[5] ^ codeword[6];
    syn[2] = codeword[3] ^ codeword[4] ^ codeword[5] ^ codeword[6];
  end

  // The syndrome names the Hamming position (1..7) to invert; zero leaves the word alone.
  always_comb begin
    corrected = codeword;
    for (int i = 0; i < 7; i++) begin
      if (syn == 3'(i + 1))
        corrected[i] = ~codeword[i];
    end
    data_next = {corrected[6], corrected[5], corrected[4], corrected[2]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      data <= 4'b0000;
    else
      data <= data_next;
  end

`ifdef HAMMING74_ERR_STATUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syndrome      <= 3'b000;
      err_corrected <= 1'b0;
    end else begin
      syndrome      <= syn;
      err_corrected <= (syn != 3'b000);
    end
  end
`endif

endmodule

// File: tb/tb_hamming74_decoder.sv
// Self-checking bench for hamming74_decoder against a position-XOR Hamming model.
// Build with HAMMING74_ERR_STATUS_EN defined to also check syndrome and err_corrected.
module tb_hamming74_decoder;

  logic       clk;
  logic       rst_n;
  logic [6:0] codeword;
  logic [3:0] data;
`ifdef HAMMING74_ERR_STATUS_EN
  logic [2:0] syndrome;
  logic       err_corrected;
`endif

  int checks;
  int errors;

  hamming74_decoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .codeword     (codeword),
    .data         (data)
`ifdef HAMMING74_ERR_STATUS_EN
    ,
    .syndrome     (syndrome),
    .err_corrected(err_corrected)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Syndrome of a Hamming word is the XOR of the position numbers of all set bits.
  function automatic logic [2:0] model_syn(input logic [6:0] w);
    int s;
    s = 0;
    for (int p = 1; p <= 7; p++)
      if (w[p-1]) s = s ^ p;
    return 3'(s);
  endfunction

  function automatic logic [3:0] model_data(input logic [6:0] w);
    logic [6:0] c;
    int k;
    c = w;
    k = int'(model_syn(w));
    if (k != 0) c[k-1] = ~c[k-1];
    return {c[6], c[5], c[4], c[2]};
  endfunction

  // Place data at positions 3,5,6,7, then set parity positions 1,2,4 to cancel the syndrome.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] w;
    logic [2:0] s;
    w = 7'b0;
    w[2] = d[0];
    w[4] = d[1];
    w[5] = d[2];
    w[6] = d[3];
    s = model_syn(w);
    w[0] = s[0];
    w[1] = s[1];
    w[3] = s[2];
    return w;
  endfunction

  task automatic applyStimulus(input logic [6:0] w);
    @(negedge clk);
    codeword = w;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    codeword = 7'b1111111;
    #2;
    checks++;
    if (data !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_async data=%b expected=0000", data);
    end
`ifdef HAMMING74_ERR_STATUS_EN
    checks++;
    if (syndrome !== 3'b000 || err_corrected !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_status syn=%b err=%b expected=000/0", syndrome, err_corrected);
    end
`endif
    @(posedge clk);
    #1;
    checks++;
    if (data !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_held data=%b expected=0000", data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (data !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL reset_release data=%b expected=1111", data);
    end
  endtask

  task automatic test_clean();
    logic [6:0] words [3];
    words[0] = 7'b0000000;
    words[1] = 7'b0000111;
    words[2] = 7'b1111111;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(words[i]);
      checks++;
      if (data !== model_data(words[i])) begin
        errors++;
        $display("[TB] FAIL clean cw=%b data=%b expected=%b", words[i], data, model_data(words[i]));
      end
    end
  endtask

  task automatic test_pos6_stream();
    logic [6:0] w;
    for (int d = 0; d < 16; d++) begin
      w = encode(4'(d));
      w[5] = ~w[5];
      applyStimulus(w);
      checks++;
      if (data !== 4'(d)) begin
        errors++;
        $display("[TB] FAIL pos6_stream cw=%b data=%b expected=%b", w, data, 4'(d));
      end
`ifdef HAMMING74_ERR_STATUS_EN
      checks++;
      if (syndrome !== 3'd6 || err_corrected !== 1'b1) begin
        errors++;
        $display("[TB] FAIL pos6_status syn=%b err=%b expected=110/1", syndrome, err_corrected);
      end
`endif
    end
  endtask

  task automatic test_single_errors();
    logic [6:0] clean;
    logic [6:0] w;
    clean = encode(4'b1010);
    for (int p = 0; p <= 7; p++) begin
      w = clean;
      if (p != 0) w[p-1] = ~w[p-1];
      applyStimulus(w);
      checks++;
      if (data !== 4'b1010) begin
        errors++;
        $display("[TB] FAIL single_err pos=%0d data=%b expected=1010", p, data);
      end
`ifdef HAMMING74_ERR_STATUS_EN
      checks++;
      if (syndrome !== 3'(p) || err_corrected !== (p != 0)) begin
        errors++;
        $display("[TB] FAIL single_status pos=%0d syn=%b err=%b expected=%b/%b",
                 p, syndrome, err_corrected, 3'(p), (p != 0));
      end
`endif
    end
  endtask

  task automatic test_parity_errors();
    logic [6:0] words [3];
    words[0] = 7'b0000001;
    words[1] = 7'b0000010;
    words[2] = 7'b0001000;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(words[i]);
      checks++;
      if (data !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL parity_err cw=%b data=%b expected=0000", words[i], data);
      end
`ifdef HAMMING74_ERR_STATUS_EN
      checks++;
      if (syndrome !== model_syn(words[i])) begin
        errors++;
        $display("[TB] FAIL parity_syn cw=%b syn=%b expected=%b", words[i], syndrome, model_syn(words[i]));
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [6:0] w;
    logic [3:0] d;
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) begin
        w = 7'($urandom_range(0, 127));
      end else begin
        d = 4'($urandom_range(0, 15));
        w = encode(d);
        w[$urandom_range(0, 6)] ^= 1'b1;
      end
      applyStimulus(w);
      checks++;
      if (data !== model_data(w)) begin
        errors++;
        $display("[TB] FAIL random cw=%b data=%b expected=%b", w, data, model_data(w));
      end
`ifdef HAMMING74_ERR_STATUS_EN
      checks++;
      if (syndrome !== model_syn(w) || err_corrected !== (model_syn(w) != 3'b000)) begin
        errors++;
        $display("[TB] FAIL random_status cw=%b syn=%b err=%b expected=%b", w, syndrome, err_corrected, model_syn(w));
      end
`endif
    end
  endtask

  task automatic test_mid_reset();
    logic [6:0] w;
    for (int d = 0; d < 16; d++) begin
      w = encode(4'(d));
      w[5] = ~w[5];
      if (d == 8) begin
        @(negedge clk);
        codeword = w;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (data !== 4'b0000) begin
          errors++;
          $display("[TB] FAIL mid_reset_async data=%b expected=0000", data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (data !== 4'b0000) begin
          errors++;
          $display("[TB] FAIL mid_reset_held data=%b expected=0000", data);
        end
        @(negedge clk);
        rst_n = 1'b1;
      end
      applyStimulus(w);
      checks++;
      if (data !== 4'(d)) begin
        errors++;
        $display("[TB] FAIL mid_reset_stream cw=%b data=%b expected=%b", w, data, 4'(d));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    codeword = 7'b0;
    test_reset();
    test_clean();
    test_pos6_stream();
    test_single_errors();
    test_parity_errors();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
